// File: rtl/stage2_decode.sv
// rtl/stage2_decode.sv - ID stage: register file, immediate decode, load-use stall, ID/EX latch
module stage2_decode #(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0][XLEN-1:0]       if_id,
    input  logic                       flush,
    input  logic                       wb_en,
    input  logic [$clog2(NREGS)-1:0]   wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    output logic [4:0][XLEN-1:0]       id_ex,
    output logic                       stall
);
    localparam int IDXW = $clog2(NREGS);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [XLEN-1:0] regs [NREGS];

    logic [XLEN-1:0] ir;
    logic [6:0]      opcode;
    logic [IDXW-1:0] rs1, rs2;
    logic [XLEN-1:0] imm, rs1_val, rs2_val;
    logic            uses_rs1, uses_rs2;
    logic            wb_commit;
    logic [6:0]      ex_opcode;
    logic [IDXW-1:0] ex_rd;

    assign ir        = if_id[0];
    assign opcode    = ir[6:0];
    assign rs1       = ir[15 +: IDXW];
    assign rs2       = ir[20 +: IDXW];
    assign wb_commit = wb_en && (wb_rd != '0);

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
            OP_STORE:                 imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            OP_BR:                    imm = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = XLEN'({ir[31:12], 12'b0});
            OP_JAL:                   imm = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default:                  imm = '0;
        endcase
    end

    // Writeback bypass lets a same-cycle write be seen by the instruction being decoded.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0) rs1_val = (wb_commit && wb_rd == rs1) ? wb_data : regs[rs1];
        if (rs2 != '0) rs2_val = (wb_commit && wb_rd == rs2) ? wb_data : regs[rs2];
    end

    assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2 = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BR);

    assign ex_opcode = id_ex[0][6:0];
    assign ex_rd     = id_ex[0][7 +: IDXW];

    always_comb begin
        stall = 1'b0;
        if (!reset && !flush && ex_opcode == OP_LOAD && ex_rd != '0)
            stall = (uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            id_ex <= {{(4*XLEN){1'b0}}, XLEN'(NOP_INSN)};
        end else begin
            if (wb_commit) regs[wb_rd] <= wb_data;
            if (flush || stall)
                id_ex <= {{(4*XLEN){1'b0}}, XLEN'(NOP_INSN)};
            else
                id_ex <= {imm, rs2_val, rs1_val, if_id[1], ir};
        end
    end
endmodule

// File: doc/stage2_decode.md
Name: stage2_decode

Overview:
- Instruction-decode / register-fetch stage of the 5-stage pipeline; sits between the fetch stage (IF/ID latch) and execute (ID/EX latch).
- Holds the 32-entry integer register file, which is written by the MEM/WB writeback port.
- Decodes RV32I immediates, reads rs1/rs2 and registers {IR, NPC, A, B, Imm} into ID/EX.
- Detects load-use hazards (drives a stall) and inserts bubbles on a branch flush.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, register-file depth; index width is log2(NREGS) = 5.
- NOP_INSN, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- if_id, input, 2 x 32, [0] = IR, [1] = NPC from fetch.
- flush, input, 1, EX/MEM.cond (taken branch); squash the instruction in decode.
- wb_en, input, 1, MEM/WB register write enable.
- wb_rd, input, 5, MEM/WB destination register.
- wb_data, input, 32, MEM/WB write data.
- id_ex, output, 5 x 32, registered: [0] IR, [1] NPC, [2] A, [3] B, [4] Imm.
- stall, output, 1, combinational load-use stall request to fetch.

Behaviour:
- Reset (synchronous, active-high): all NREGS registers = 0; id_ex[0] = NOP_INSN; id_ex[1..4] = 0.
  - Reset has priority over every other input.
- Field extraction from IR = if_id[0]:
  - opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- Immediate generation (sign-extended to 32 bits):
  - I-type (0010011, 0000011, 1100111): IR[31:20].
  - S-type (0100011): {IR[31:25], IR[11:7]}.
  - B-type (1100011): {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - U-type (0110111, 0010111): {IR[31:12], 12'b0}; no sign extension.
  - J-type (1101111): {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - Any other opcode: 0.
- Register file:
  - Write on the clk edge when wb_en && wb_rd != 0; writes to x0 are ignored, and x0 always reads 0.
  - Read is combinational with write-bypass: if wb_en && wb_rd != 0 && wb_rd == rsN, the read returns wb_data.
- Operand-use sets:
  - uses_rs1 = every opcode except LUI, AUIPC and JAL.
  - uses_rs2 = R (0110011), S (0100011), B (1100011).
- stall (combinational):
  - Asserted when id_ex[0] opcode == 0000011, its rd != 0, and (uses_rs1 && rd == rs1) or (uses_rs2 && rd == rs2).
  - Forced 0 while flush or reset is high.
- Per-cycle update priority: reset > flush > stall > normal.
  - flush: id_ex[0] = NOP_INSN, id_ex[1..4] = 0.
  - stall: same bubble as flush. Fetch is responsible for holding if_id, so the instruction is re-decoded next cycle.
  - normal: id_ex = {IR, NPC, A, B, Imm}. Latency is 1 cycle from if_id to id_ex.
- Simultaneous writeback and read of the same register in one cycle: id_ex captures the new wb_data (bypass).
- Writeback is independent of flush and stall; it still commits during bubbles.
- Reset mid-stall: the bubble is replaced by the reset values, stall drops in the same cycle, and the register file is cleared.
- There is exactly 1 stall cycle per load-use pair, because the load then leaves ID/EX.

Test Plan:
- Reset: hold reset 2 cycles with random if_id -> id_ex[0] = 0x00000013, id_ex[1..4] = 0; a later read of x5 returns 0.
- Writeback + bypass: wb x3 = 0xDEADBEEF in the same cycle as IR = add x1,x3,x0 (0x000180B3), NPC = 7 -> next cycle id_ex = {0x000180B3, 7, 0xDEADBEEF, 0, 0}. A following read of x3 without wb returns 0xDEADBEEF.
- x0 protection: wb_en = 1, wb_rd = 0, wb_data = 0x1234, then IR = addi x2,x0,-1 (0xFFF00113) -> A = 0, Imm = 0xFFFFFFFF.
- Immediates:
  - sw x5,-4(x1) (0xFE50AE23) -> Imm = 0xFFFFFFFC.
  - beq x0,x0,-8 (0xFE000CE3) -> Imm = 0xFFFFFFF8.
  - lui x1,0x12345 (0x123450B7) -> Imm = 0x12345000.
  - jal x1,+2048 (0x001000EF) -> Imm = 0x00000800.
- Load-use: lw x4,0(x1) (0x0000A203) is decoded, then IR = add x5,x4,x0 (0x000202B3) -> stall = 1 for exactly 1 cycle and id_ex[0] = NOP. With if_id held, the next cycle id_ex[0] = 0x000202B3 and stall = 0. Repeat with lui x4 as the consumer -> no stall.
- Flush: flush = 1 with a valid IR and a pending load-use hazard -> stall = 0, id_ex = NOP bubble; a simultaneous wb of x7 = 0x55 still commits.
